collision_scanner: RTL
======================

// Module: collision_scanner
// PURPOSE
//  Sequential, parametrised frog-vs-obstacle collision checker for NUM_CARS lanes objects.
//  On a start pulse (one per frame, from the VGA frame tick), it snapshots all coordinates.
//  It then tests one car per clock and reports death/win plus the lowest hit index.
//  Sits between the object-position logic and the game-state FSM.
// PARAMETERS
//  NUM_CARS   8    number of obstacles scanned (1..64)
//  COORD_W    10   coordinate width, pixels
//  TILE_SIZE  32   sprite edge length, pixels, for frog and cars
//  WIN_Y      0    frog_y <= WIN_Y counts as reaching the goal row
//  IDX_W      $clog2(NUM_CARS) (min 1)   width of hit_index
// PORTS
//  clk             in   1                  system clock
//  rst_n           in   1                  asynchronous active-low reset
//  start           in   1                  1-cycle request: snapshot and scan
//  frog_x, frog_y  in   COORD_W            frog top-left corner
//  car_x_flat      in   NUM_CARS*COORD_W   car i x at [i*COORD_W +: COORD_W]
//  car_y_flat      in   NUM_CARS*COORD_W   car i y, same packing
//  car_active      in   NUM_CARS           1 = car i on screen and checked
//  busy            out  1                  scan in progress (start ignored)
//  done            out  1                  1-cycle pulse: results updated this cycle
//  death_collision out  1                  frog overlaps >=1 active car (held until next done)
//  win_collision   out  1                  frog reached goal row and no death (held)
//  hit_index       out  IDX_W              lowest colliding car index; 0 if none (held)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, every output 0, scan index 0, snapshot regs 0.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: start=1 at edge T.
//    - Latch frog_x/y, car_x/y_flat and car_active into snapshot registers.
//    - Clear accumulators (hit flag, first index); set idx=0; go to SCAN.
//  - SCAN: edges T+1..T+NUM_CARS, one car per cycle, car idx.
//    - If car is active and overlaps, set hit flag; record idx only if first hit.
//    - idx increments; at idx==NUM_CARS-1 go to DONE.
//  - DONE: edge T+NUM_CARS+1.
//    - Registered outputs update; done=1 for exactly one cycle; go to IDLE.
//    - Total latency: NUM_CARS+1 cycles from start to done.
//  - busy=1 in SCAN and DONE. start while busy is dropped, not queued.
//    start in the DONE->IDLE cycle is accepted on the next IDLE edge only.
//  - Overlap rule (strict AABB), computed in COORD_W+1 bits so +TILE_SIZE never wraps:
//    fx < cx+T && cx < fx+T && fy < cy+T && cy < fy+T.
//    Edge-touching (fx == cx+T) is NOT a collision.
//  - Win: win_raw = (snap_fy <= WIN_Y). win_collision = win_raw & ~death (death has priority).
//  - Inactive cars never collide, regardless of their coordinates.
//  - Inputs changing mid-scan have no effect; only the snapshot is used.
//  - rst_n low mid-scan: immediate IDLE, outputs 0, and no done pulse is emitted.
//  - Outputs are stable between done pulses; consumers sample on done.
// STRUCTURE
//  - collision_defs.vh: TILE_SIZE default, FSM state encodings (S_IDLE=2'd0, S_SCAN=2'd1,
//    S_DONE=2'd2), and the shared coordinate width.
//  - Sub-module aabb_overlap (params COORD_W, TILE_SIZE): purely combinational, 4 compares,
//    output overlap. One instance, fed from the car muxed by idx.
//  - Top level: FSM, idx counter, snapshot registers, car mux, accumulators, output regs.
// TESTING
//  1. Reset/idle: rst_n=0 then 1, no start for 50 cycles -> all outputs 0, busy=0, done never 1.
//  2. Single hit: NUM_CARS=8, frog (100,200), car3 (120,210) active, others inactive at (100,200)
//     -> done 9 cycles after start; death=1, hit_index=3, win=0.
//  3. Edge touch and wrap: frog (64,0) with car0 (32,0) -> death=0, win=1.
//     Then frog (1000,300) with car1 (1010,300) -> death=1, no wrap error.
//  4. Multiple hits and priority: cars 2 and 6 overlap the frog, frog_y=0 -> death=1, hit_index=2, win=0.
//  5. Mid-scan changes: start, then change all inputs and pulse start at cycle +3
//     -> results match the first snapshot; the second start is ignored; exactly one done.
//  6. Reset mid-scan: assert rst_n=0 at cycle +4 after start -> outputs 0 immediately, no done.
//     A new start after release completes normally.

Source files
------------

// File: rtl/collision_scanner_pkg.sv
// -----------------------------------------------------------------------------
// collision_scanner_pkg
//   Shared definitions for the frog-vs-obstacle collision scanner:
//   default sprite/coordinate sizes, FSM state encoding and an index-width
//   helper used to size hit_index.
// -----------------------------------------------------------------------------
package collision_scanner_pkg;

    // Default sprite edge length (frog and cars), pixels.
    localparam int TILE_SIZE_DEF = 32;

    // Default coordinate width, pixels.
    localparam int COORD_W_DEF = 10;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a car index; never narrower than one bit, so a single-car
    // build still has a legal hit_index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_scanner_aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
//   Purely combinational strict axis-aligned box overlap test between the
//   frog sprite and one car sprite. Both boxes are TILE_SIZE x TILE_SIZE with
//   their top-left corner given. Touching edges do not count as overlap.
//
// Ports
//   fx, fy   in   COORD_W   frog top-left corner
//   cx, cy   in   COORD_W   car top-left corner
//   overlap  out  1         1 = the two boxes share interior area
// -----------------------------------------------------------------------------
module aabb_overlap #(
    parameter int COORD_W   = 10,
    parameter int TILE_SIZE = 32
) (
    input  logic [COORD_W-1:0] fx,
    input  logic [COORD_W-1:0] fy,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               overlap
);

    // One extra bit of headroom so that corner + TILE never wraps, e.g. a
    // frog at x=1000 still ends at 1032 rather than 8.
    localparam logic [COORD_W:0] TILE = (COORD_W + 1)'(TILE_SIZE);

    logic [COORD_W:0] fx_w;
    logic [COORD_W:0] fy_w;
    logic [COORD_W:0] cx_w;
    logic [COORD_W:0] cy_w;
    logic [COORD_W:0] fx_end;
    logic [COORD_W:0] fy_end;
    logic [COORD_W:0] cx_end;
    logic [COORD_W:0] cy_end;

    assign fx_w   = {1'b0, fx};
    assign fy_w   = {1'b0, fy};
    assign cx_w   = {1'b0, cx};
    assign cy_w   = {1'b0, cy};
    assign fx_end = fx_w + TILE;
    assign fy_end = fy_w + TILE;
    assign cx_end = cx_w + TILE;
    assign cy_end = cy_w + TILE;

    assign overlap = (fx_w < cx_end) && (cx_w < fx_end) &&
                     (fy_w < cy_end) && (cy_w < fy_end);

endmodule

// File: rtl/collision_scanner.sv
// -----------------------------------------------------------------------------
// collision_scanner
//   Sequential frog-vs-obstacle collision checker. A one-cycle start
//   snapshots every coordinate, then one car is tested per clock. After the
//   last car the results are published together with a one-cycle done pulse.
//   Latency from the start edge to the done edge is NUM_CARS+1 cycles.
//
// Ports
//   clk              in   1                  system clock
//   rst_n            in   1                  asynchronous active-low reset
//   start            in   1                  snapshot-and-scan request (ignored while busy)
//   frog_x, frog_y   in   COORD_W            frog top-left corner
//   car_x_flat       in   NUM_CARS*COORD_W   car i x at [i*COORD_W +: COORD_W]
//   car_y_flat       in   NUM_CARS*COORD_W   car i y, same packing
//   car_active       in   NUM_CARS           1 = car i is on screen and checked
//   busy             out  1                  scan in progress
//   done             out  1                  one-cycle pulse: results updated
//   death_collision  out  1                  frog overlaps at least one active car
//   win_collision    out  1                  frog in goal row and not dead
//   hit_index        out  IDX_W              lowest colliding car index, 0 if none
// -----------------------------------------------------------------------------
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int NUM_CARS  = 8,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int TILE_SIZE = TILE_SIZE_DEF,
    parameter int WIN_Y     = 0,
    parameter int IDX_W     = idx_width(NUM_CARS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [COORD_W-1:0]          frog_x,
    input  logic [COORD_W-1:0]          frog_y,
    input  logic [NUM_CARS*COORD_W-1:0] car_x_flat,
    input  logic [NUM_CARS*COORD_W-1:0] car_y_flat,
    input  logic [NUM_CARS-1:0]         car_active,
    output logic                        busy,
    output logic                        done,
    output logic                        death_collision,
    output logic                        win_collision,
    output logic [IDX_W-1:0]            hit_index
);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CARS - 1);
    localparam logic [COORD_W:0]   WIN_LIM  = (COORD_W + 1)'(WIN_Y);

    state_t state;
    state_t state_next;

    // Control strobes decoded from the current state.
    logic snap_load;
    logic scan_en;
    logic publish;

    // Snapshot of the frame's geometry.
    logic [COORD_W-1:0]  snap_fx;
    logic [COORD_W-1:0]  snap_fy;
    logic [COORD_W-1:0]  snap_cx [NUM_CARS];
    logic [COORD_W-1:0]  snap_cy [NUM_CARS];
    logic [NUM_CARS-1:0] snap_act;

    // Scan position and accumulators.
    logic [IDX_W-1:0] idx;
    logic             hit_flag;
    logic [IDX_W-1:0] first_idx;

    // Currently selected car and its test result.
    logic [COORD_W-1:0] cur_cx;
    logic [COORD_W-1:0] cur_cy;
    logic               cur_overlap;
    logic               car_hit;
    logic               win_raw;

    // -------------------------------------------------------------------------
    // Sequencer: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample the pre-edge values of each other, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: next state and strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        snap_load  = 1'b0;
        scan_en    = 1'b0;
        publish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_load  = 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                publish    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Start requests arriving in SCAN or DONE fall through the IDLE-only
    // accept above, so they are dropped rather than queued.
    assign busy = (state == S_SCAN) || (state == S_DONE);

    // -------------------------------------------------------------------------
    // Car selection and overlap test
    // -------------------------------------------------------------------------
    assign cur_cx = snap_cx[idx];
    assign cur_cy = snap_cy[idx];

    aabb_overlap #(
        .COORD_W   (COORD_W),
        .TILE_SIZE (TILE_SIZE)
    ) u_overlap (
        .fx      (snap_fx),
        .fy      (snap_fy),
        .cx      (cur_cx),
        .cy      (cur_cy),
        .overlap (cur_overlap)
    );

    // Inactive cars are masked here, so their coordinates never matter.
    assign car_hit = snap_act[idx] & cur_overlap;

    assign win_raw = ({1'b0, snap_fy} <= WIN_LIM);

    // -------------------------------------------------------------------------
    // Snapshot, scan accumulators and published results
    // -------------------------------------------------------------------------
    // NOTE: the snapshot arrays are only NUM_CARS entries of flops (not a RAM),
    // so they are cleared on reset like any other register; this keeps the
    // post-reset state fully defined at negligible cost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_fx         <= '0;
            snap_fy         <= '0;
            snap_act        <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                snap_cx[i] <= '0;
                snap_cy[i] <= '0;
            end
            idx             <= '0;
            hit_flag        <= 1'b0;
            first_idx       <= '0;
            done            <= 1'b0;
            death_collision <= 1'b0;
            win_collision   <= 1'b0;
            hit_index       <= '0;
        end else begin
            done <= publish;

            if (snap_load) begin
                snap_fx  <= frog_x;
                snap_fy  <= frog_y;
                snap_act <= car_active;
                for (int i = 0; i < NUM_CARS; i++) begin
                    snap_cx[i] <= car_x_flat[i*COORD_W +: COORD_W];
                    snap_cy[i] <= car_y_flat[i*COORD_W +: COORD_W];
                end
                idx       <= '0;
                hit_flag  <= 1'b0;
                first_idx <= '0;
            end

            if (scan_en) begin
                // Cars are visited in ascending order, so the first hit seen
                // is the lowest index; later hits only keep the flag set.
                if (car_hit) begin
                    hit_flag <= 1'b1;
                    if (!hit_flag) begin
                        first_idx <= idx;
                    end
                end
                idx <= idx + IDX_W'(1);
            end

            if (publish) begin
                death_collision <= hit_flag;
                win_collision   <= win_raw & ~hit_flag;
                hit_index       <= first_idx;
            end
        end
    end

endmodule
